// File: rtl/byter_pkg.sv
// Shared constants and types for the byter CPU core.
package byter_pkg;
    localparam int PC_WIDTH = 12;
    localparam int PC_RESET = 0;
    typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc_next.sv
// Next program-counter value, purely combinational. Priority is load, then increment, then hold.
// Latency 0 (comb); no backpressure.
module pc_next #(
    parameter int WIDTH = 12
) (
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] pre_load_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] nxt_o
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        nxt_o = cur_i;
        if (load_i) begin
            nxt_o = pre_load_i;
        end else if (enable_i) begin
            // Increment wraps modulo 2^WIDTH. The carry is dropped on purpose.
            nxt_o = cur_i + ONE;
        end
    end
endmodule

// File: rtl/program_counter.sv
// Fetch-address register. Async active-low clear, then load, then increment, then hold.
// Latency 1 clk from enable/load to value; no backpressure (every edge is accepted).
module program_counter
    import byter_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pre_load,
    output logic [WIDTH-1:0] value
);
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    pc_next #(.WIDTH(WIDTH)) u_pc_next (
        .load_i     (load),
        .enable_i   (enable),
        .pre_load_i (pre_load),
        .cur_i      (value_q),
        .nxt_o      (value_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= RESET_VALUE;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: tb/tb_program_counter.sv
// Randomized and directed checks of program_counter against an arithmetic reference model.
module tb_program_counter;
    logic        clk;
    logic        enable;
    logic        reset;
    logic        load;
    logic [11:0] pre_load;
    logic [11:0] value;

    int vectors;
    int miscompares;
    int exp;

    program_counter dut (
        .clk      (clk),
        .enable   (enable),
        .reset    (reset),
        .load     (load),
        .pre_load (pre_load),
        .value    (value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge. The reference model applies the specification's rules
    // to the inputs held across that edge, and the task returns 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        if (reset == 1'b0)     exp = 0;
        else if (load == 1'b1) exp = int'(pre_load);
        else if (enable)       exp = (exp + 1) % 4096;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; load = 1'b0; pre_load = 12'd0;
        exp = 0;
        #1;
        vectors++;
        if (value !== 12'(exp)) begin
            miscompares++;
            $display("FAIL reset_initial: got %0d want %0d", value, exp);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (value !== 12'd0) begin
                miscompares++;
                $display("FAIL reset_hold_%0d: got %0d want 0", i, value);
            end
        end
    endtask

    task automatic test_count();
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            vectors++;
            if (value !== 12'(i) || exp != i) begin
                miscompares++;
                $display("FAIL count_%0d: got %0d want %0d", i, value, i);
            end
        end
    endtask

    task automatic test_hold();
        load = 1'b1; pre_load = 12'd5; enable = 1'b0;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pre_load = 12'($urandom);
            cycle();
            vectors++;
            if (value !== 12'd5) begin
                miscompares++;
                $display("FAIL hold_%0d: got %0d want 5", i, value);
            end
        end
    endtask

    task automatic test_load();
        enable = 1'b1; load = 1'b1; pre_load = 12'd15;
        cycle();
        vectors++;
        if (value !== 12'd15) begin
            miscompares++;
            $display("FAIL load_with_enable: got %0d want 15", value);
        end
        load = 1'b0;
        for (int i = 16; i <= 17; i++) begin
            pre_load = 12'($urandom);
            cycle();
            vectors++;
            if (value !== 12'(i)) begin
                miscompares++;
                $display("FAIL load_resume_%0d: got %0d want %0d", i, value, i);
            end
        end
        enable = 1'b0; load = 1'b1; pre_load = 12'd15;
        cycle();
        load = 1'b0;
        vectors++;
        if (value !== 12'd15) begin
            miscompares++;
            $display("FAIL load_no_enable: got %0d want 15", value);
        end
    endtask

    task automatic test_wrap();
        enable = 1'b1; load = 1'b1; pre_load = 12'd4095;
        cycle();
        load = 1'b0;
        vectors++;
        if (value !== 12'd4095) begin
            miscompares++;
            $display("FAIL wrap_load: got %0d want 4095", value);
        end
        for (int i = 0; i <= 1; i++) begin
            cycle();
            vectors++;
            if (value !== 12'(i)) begin
                miscompares++;
                $display("FAIL wrap_%0d: got %0d want %0d", i, value, i);
            end
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; load = 1'b1; pre_load = 12'd19;
        cycle();
        load = 1'b0;
        cycle();
        vectors++;
        if (value !== 12'd20) begin
            miscompares++;
            $display("FAIL async_setup: got %0d want 20", value);
        end
        #3;
        reset = 1'b0;
        exp = 0;
        #1;
        vectors++;
        if (value !== 12'd0) begin
            miscompares++;
            $display("FAIL async_mid_cycle: got %0d want 0", value);
        end
        load = 1'b1; pre_load = 12'd15;
        @(negedge clk);
        cycle();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (value !== 12'd0) begin
                miscompares++;
                $display("FAIL async_held_%0d: got %0d want 0", i, value);
            end
            if (i < 2) cycle();
        end
        reset = 1'b1; load = 1'b0;
        cycle();
        vectors++;
        if (value !== 12'd1) begin
            miscompares++;
            $display("FAIL async_release: got %0d want 1", value);
        end
    endtask

    task automatic test_priority();
        reset = 1'b0; load = 1'b1; pre_load = 12'd15; enable = 1'b1;
        exp = 0;
        #2;
        vectors++;
        if (value !== 12'd0) begin
            miscompares++;
            $display("FAIL priority_async: got %0d want 0", value);
        end
        cycle();
        vectors++;
        if (value !== 12'd0) begin
            miscompares++;
            $display("FAIL priority_edge: got %0d want 0", value);
        end
        reset = 1'b1; load = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable   = 1'($urandom);
            load     = ($urandom_range(0, 5) == 0);
            pre_load = ($urandom_range(0, 3) == 0) ? 12'd4094 : 12'($urandom);
            reset    = ($urandom_range(0, 29) != 0);
            if (!reset) exp = 0;
            cycle();
            vectors++;
            if (value !== 12'(exp)) begin
                miscompares++;
                $display("FAIL random_%0d: got %0d want %0d", i, value, exp);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_count();
        test_hold();
        test_load();
        test_wrap();
        test_async_reset();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
